// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a one-entry valid/ready output register.
//
// The line is synchronised, then a five-state FSM finds the start bit, checks
// it again half a bit later, and samples the eight data bits (LSB first) and
// the stop bit in the middle of each bit. A good frame is offered on
// o_data/o_valid. A frame whose stop bit is low is dropped and o_frame_err
// pulses. After that, the receiver waits for the line to return high.
//
// Parameters
//   input_clk_hz  clock frequency in Hz
//   baud_rate     line bit rate; CLKS_PER_BIT = input_clk_hz / baud_rate
//                 (it must be at least 2, so that HALF_BIT is non-zero)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active low
//   i_rx         asynchronous serial input, idle high
//   i_ready      consumer accepts o_data when high together with o_valid
//   o_data       last received byte
//   o_valid      o_data holds a byte not yet consumed
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte completed while the previous one was
//                still pending (the new byte is dropped)
//   o_busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int input_clk_hz = 12_000_000,
  parameter int baud_rate    = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = input_clk_hz / baud_rate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  // Terminal counts: the counter runs 0..N-1, so it never wraps inside a bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle level so that reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: every clocked process uses non-blocking assignments, so all flops
  // sample their inputs from before the edge. A blocking assignment here would
  // merge the two synchroniser stages into one.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             byte_done;
  logic             frame_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: next state and per-bit sampling
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default at the top of the block. Then any path
  // through the case statement that does not assign a signal keeps the
  // default, and no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    byte_done = 1'b0;
    frame_err = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = ST_START;
      end

      // Check the start bit again half a bit later. If the line is high by
      // then, the low level was a glitch and is ignored without a trace.
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // The start-bit check happened at mid-bit, so each full bit period
      // from there lands in the middle of the next bit.
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_n   = ST_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = ST_WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // A line held low (break) must not be read as a stream of start bits.
      ST_WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Output register: a one-entry buffer, independent of the FSM state. If the
  // consumer takes the pending byte in the same cycle that a new byte
  // completes, the new byte replaces it. Otherwise the new byte is dropped and
  // o_overrun pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_err;
      o_overrun   <= byte_done && o_valid && !i_ready;
      if (byte_done && (!o_valid || i_ready)) begin
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 12 MHz / 1 Mbaud
// (12 clocks per bit).
//
// The stimulus process sends each frame one bit at a time. Before sending a
// frame, it asks a small transaction-level model what that frame should
// produce. The model then does one of three things:
//   - pushes the expected byte onto a queue,
//   - counts an expected frame error, or
//   - counts an expected overrun.
// A monitor on the falling clock edge pops the queue at each valid/ready
// handshake and compares the byte. It also counts the error and overrun
// pulses. The stimulus process compares those counts with the model's counts
// at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int C      = CLK_HZ / BAUD;  // clocks per bit
  localparam int H      = C / 2;          // half bit
  localparam int LAT    = 2 + H + 9 * C;  // nominal fall-to-valid latency

  logic       i_clk   = 1'b0;
  logic       i_rst   = 1'b0;
  logic       i_rx    = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx #(
    .input_clk_hz(CLK_HZ),
    .baud_rate   (BAUD)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what one frame means at the transaction level.
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         exp_ferr      = 0;
  int         exp_ovr       = 0;
  bit         model_pending = 1'b0;

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)          exp_ferr++;
    else if (model_pending) exp_ovr++;
    else begin
      exp_q.push_back(b);
      model_pending = !i_ready;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int   ferr_seen     = 0;
  int   ovr_seen      = 0;
  int   valid_cycles  = 0;
  int   valid_rise    = 0;
  logic prev_valid    = 1'b0;

  always @(negedge i_clk) begin
    if (o_frame_err === 1'b1) ferr_seen++;
    if (o_overrun === 1'b1)   ovr_seen++;
    if (o_valid === 1'b1) begin
      valid_cycles++;
      if (!prev_valid) valid_rise = cyc;
    end
    prev_valid = (o_valid === 1'b1);
    if (o_valid === 1'b1 && i_ready && i_rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", o_data);
      end else begin
        check("rx_byte", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line driver: each call holds one bit for a full bit period.
  // ---------------------------------------------------------------------------
  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (C) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err_count"}, ferr_seen, exp_ferr);
    check({tag, "_overrun_count"}, ovr_seen, exp_ovr);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         fall_cyc;
    logic [7:0] rb;
    logic [7:0] partial;

    // Reset state
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_data",      {24'd0, o_data}, 32'h00);
    check("reset_valid",     {31'd0, o_valid}, 32'd0);
    check("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
    check("reset_overrun",   {31'd0, o_overrun}, 32'd0);
    check("reset_busy",      {31'd0, o_busy}, 32'd0);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // Single byte 8'hA5: latency, one-cycle valid, no error pulses.
    valid_cycles = 0;
    fall_cyc     = cyc;
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    check_range("a5_latency", valid_rise - fall_cyc, LAT - 1, LAT + 1);
    check("a5_valid_cycles", valid_cycles, 1);
    check_counts("a5");

    // A 4-cycle low glitch: the FSM goes busy, then returns to IDLE quietly.
    valid_cycles = 0;
    i_rx = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    check("glitch_busy_high", {31'd0, o_busy}, 32'd1);
    i_rx = 1'b1;
    repeat (H + 3) @(posedge i_clk);
    #1;
    check("glitch_busy_low", {31'd0, o_busy}, 32'd0);
    idle_bits(2);
    check("glitch_valid_cycles", valid_cycles, 0);
    check_counts("glitch");

    // Framing error on 8'h3C, then a good 8'h81.
    valid_cycles = 0;
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    idle_bits(2);
    check("ferr_valid_cycles", valid_cycles, 0);
    check_counts("ferr");
    model_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check_counts("after_ferr");

    // Overrun: hold i_ready low across two frames.
    i_ready = 1'b0;
    model_frame(8'h11, 1'b1);
    send_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(1);
    check("ovr_data_held",  {24'd0, o_data}, 32'h11);
    check("ovr_valid_held", {31'd0, o_valid}, 32'd1);
    check_counts("ovr");
    i_ready       = 1'b1;
    model_pending = 1'b0;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    check("ovr_valid_dropped", {31'd0, o_valid}, 32'd0);
    i_ready = 1'b1;

    // Reset in the middle of data bit 4. Bits 4..7 and the stop bit are high,
    // so after reset is released the line looks idle.
    valid_cycles = 0;
    partial      = 8'hF3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    i_rx = partial[4];
    repeat (H) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_data",  {24'd0, o_data}, 32'h00);
    check("midrst_ferr",  {31'd0, o_frame_err}, 32'd0);
    check("midrst_ovr",   {31'd0, o_overrun}, 32'd0);
    i_rst = 1'b1;
    repeat (C - H - 2) @(posedge i_clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(partial[i]);
    drive_bit(1'b1);
    idle_bits(10);
    check("midrst_no_output", valid_cycles, 0);
    model_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);

    // Random bytes with random idle gaps.
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      model_frame(rb, 1'b1);
      send_frame(rb, 1'b1);
      repeat ($urandom_range(0, 20)) @(posedge i_clk);
      #1;
    end
    idle_bits(1);

    // Back-to-back 8'h00 then 8'hFF with no idle gap.
    valid_cycles = 0;
    model_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    model_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(3);
    check("b2b_valid_cycles", valid_cycles, 2);

    check("pending_expected_bytes", exp_q.size(), 0);
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
